// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg -- shared definitions for the SDRAM command arbiter.
//   Command encodings are {cs_n, ras_n, cas_n, we_n}.
//   Arbiter states are one-hot so each grant is a single-bit decode.
//   Default address/bank widths for the arbiter parameters.
// ---------------------------------------------------------------------------
package sdram_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int BA_W_DEF   = 2;

   localparam logic [3:0] CMD_NOP   = 4'b1000;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_AREF  = 4'b0001;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b0101;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_ARBIT = 5'b00010,
      ST_AREF  = 5'b00100,
      ST_WRITE = 5'b01000,
      ST_READ  = 5'b10000
   } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit -- arbitrates SDRAM command sources (init, refresh, write,
// read) onto one registered command/address/bank port.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   init_end                 initialisation done (level); low forces IDLE
//   init_cmd/addr/ba         init command source (used while in IDLE)
//   {aref,wr,rd}_req         level requests, sampled only in ARBIT
//   {aref,wr,rd}_end         1-cycle done pulses from the granted source
//   {aref,wr,rd}_cmd/addr/ba command sources
//   aref_en, wr_en, rd_en    grants (state decodes, at most one high)
//   sdram_cs_n/ras_n/cas_n/we_n, sdram_addr, sdram_ba
//                            registered muxed command (1-cycle latency)
//
// Build option: define SDRAM_ARB_RW_FAIR_EN to alternate write/read when
// both request together; refresh always wins. Undefined: write beats read.
// ---------------------------------------------------------------------------
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BA_W   = BA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_end,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [BA_W-1:0]   init_ba,
   input  logic              aref_req,
   input  logic              aref_end,
   input  logic [3:0]        aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic [BA_W-1:0]   aref_ba,
   input  logic              wr_req,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic              rd_req,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BA_W-1:0]   rd_ba,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [BA_W-1:0]   sdram_ba
);

   arb_state_e        state_q, state_d;
   arb_state_e        sel_st;
   logic              pick_wr;
   logic [3:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BA_W-1:0]   ba_q, ba_d;

`ifdef SDRAM_ARB_RW_FAIR_EN
   // 1 = write was served last; reset value means "read served last"
   logic last_wr_q, last_wr_d;
   assign pick_wr = wr_req & (~rd_req | ~last_wr_q);
`else
   assign pick_wr = wr_req;
`endif

   always_comb begin
      state_d = state_q;
`ifdef SDRAM_ARB_RW_FAIR_EN
      last_wr_d = last_wr_q;
`endif
      if (!init_end) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = ST_ARBIT;
            ST_ARBIT: begin
               if (aref_req) begin
                  state_d = ST_AREF;
               end else if (wr_req || rd_req) begin
                  state_d = pick_wr ? ST_WRITE : ST_READ;
`ifdef SDRAM_ARB_RW_FAIR_EN
                  last_wr_d = pick_wr;
`endif
               end
            end
            ST_AREF:  if (aref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
            ST_READ:  if (rd_end)   state_d = ST_ARBIT;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Losing init_end hands the pins back to the init source immediately,
   // matching the grants, which drop in the same cycle.
   assign sel_st = init_end ? state_q : ST_IDLE;

   always_comb begin
      cmd_d  = CMD_NOP;
      addr_d = '1;
      ba_d   = '1;
      unique case (sel_st)
         ST_IDLE:  begin cmd_d = init_cmd; addr_d = init_addr; ba_d = init_ba; end
         ST_AREF:  begin cmd_d = aref_cmd; addr_d = aref_addr; ba_d = aref_ba; end
         ST_WRITE: begin cmd_d = wr_cmd;   addr_d = wr_addr;   ba_d = wr_ba;   end
         ST_READ:  begin cmd_d = rd_cmd;   addr_d = rd_addr;   ba_d = rd_ba;   end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cmd_q   <= CMD_NOP;
         addr_q  <= '0;
         ba_q    <= '0;
`ifdef SDRAM_ARB_RW_FAIR_EN
         last_wr_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         ba_q    <= ba_d;
`ifdef SDRAM_ARB_RW_FAIR_EN
         last_wr_q <= last_wr_d;
`endif
      end
   end

   assign aref_en = init_end & (state_q == ST_AREF);
   assign wr_en   = init_end & (state_q == ST_WRITE);
   assign rd_en   = init_end & (state_q == ST_READ);

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
   assign sdram_addr = addr_q;
   assign sdram_ba   = ba_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit -- directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of who owns the SDRAM port.
// ---------------------------------------------------------------------------
module tb_sdram_arbit;

   localparam int AW = 13;
   localparam int BW = 2;
   localparam int P_IDLE = 0, P_ARB = 1, P_AREF = 2, P_WR = 3, P_RD = 4;

   logic clk = 0;
   logic rst = 1;
   logic init_end = 0, aref_req = 0, aref_end = 0, wr_req = 0, wr_end = 0, rd_req = 0, rd_end = 0;
   logic [3:0] init_cmd = 4'b0010, aref_cmd = 4'b0001, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
   logic [AW-1:0] init_addr = '0, aref_addr = '0, wr_addr = '0, rd_addr = '0;
   logic [BW-1:0] init_ba = '0, aref_ba = '0, wr_ba = '0, rd_ba = '0;
   logic aref_en, wr_en, rd_en;
   logic cs_n, ras_n, cas_n, we_n;
   logic [AW-1:0] s_addr;
   logic [BW-1:0] s_ba;
   wire  [18:0] pins = {cs_n, ras_n, cas_n, we_n, s_addr, s_ba};

   int n_cmp = 0;
   int n_err = 0;

   // model: current owner of the port, expected registered pins, fairness memory
   int          m_ph;
   logic [18:0] m_pins;
   bit          m_lastw;

   sdram_arbit #(.ADDR_W(AW), .BA_W(BW)) dut (
      .clk(clk), .rst(rst), .init_end(init_end),
      .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba),
      .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_ba(aref_ba),
      .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
      .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
      .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
      .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
      .sdram_addr(s_addr), .sdram_ba(s_ba)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph    = P_IDLE;
      m_pins  = {4'b1000, {AW{1'b0}}, {BW{1'b0}}};
      m_lastw = 0;
   endtask

   task automatic check_model();
      chk("aref_en", aref_en, (m_ph == P_AREF) && init_end && !rst);
      chk("wr_en",   wr_en,   (m_ph == P_WR)   && init_end && !rst);
      chk("rd_en",   rd_en,   (m_ph == P_RD)   && init_end && !rst);
      chk("onehot",  ($countones({aref_en, wr_en, rd_en}) <= 1), 1);
      chk("pins",    pins, m_pins);
   endtask

   // What the port does on the coming clock edge, from the current owner and inputs.
   task automatic model_advance();
      int nph;
      bit take_wr;
      nph = m_ph;
      if (!init_end || m_ph == P_IDLE)
         m_pins = {init_cmd, init_addr, init_ba};
      else if (m_ph == P_ARB)  m_pins = {4'b1000, {AW{1'b1}}, {BW{1'b1}}};
      else if (m_ph == P_AREF) m_pins = {aref_cmd, aref_addr, aref_ba};
      else if (m_ph == P_WR)   m_pins = {wr_cmd, wr_addr, wr_ba};
      else                     m_pins = {rd_cmd, rd_addr, rd_ba};
      if (!init_end) nph = P_IDLE;
      else if (m_ph == P_IDLE) nph = P_ARB;
      else if (m_ph == P_ARB) begin
`ifdef SDRAM_ARB_RW_FAIR_EN
         take_wr = wr_req && !(rd_req && m_lastw);
`else
         take_wr = wr_req;
`endif
         if (aref_req) nph = P_AREF;
         else if (take_wr) begin nph = P_WR; m_lastw = 1; end
         else if (rd_req)  begin nph = P_RD; m_lastw = 0; end
      end
      else if (m_ph == P_AREF && aref_end) nph = P_ARB;
      else if (m_ph == P_WR && wr_end)     nph = P_ARB;
      else if (m_ph == P_RD && rd_end)     nph = P_ARB;
      m_ph = nph;
   endtask

   // Called just after a negedge with inputs set; returns at the next negedge.
   task automatic step();
      #1;
      check_model();
      model_advance();
      @(negedge clk);
   endtask

   task automatic pulse_rst();
      rst = 1;
      #1;
      chk("rst_grants", {aref_en, wr_en, rd_en}, 3'b000);
      chk("rst_pins", pins, {4'b1000, {AW{1'b0}}, {BW{1'b0}}});
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      logic [2:0] fair_pat;
      bit exp_w;
      model_reset();
      init_addr = 13'h0a5a; init_ba = 2'd1;
      aref_addr = 13'h0400; wr_addr = 13'h1234; wr_ba = 2'd2; rd_addr = 13'h0777; rd_ba = 2'd3;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_pins", pins, {4'b1000, {AW{1'b0}}, {BW{1'b0}}});
      chk("reset_grants", {aref_en, wr_en, rd_en}, 3'b000);
      @(negedge clk);
      rst = 0;

      // init source reaches the pins one cycle after reset release
      step();
      step();
      chk("init_cmd_pins", pins[18:15], 4'b0010);
      chk("init_grants", {aref_en, wr_en, rd_en}, 3'b000);

      // simultaneous requests: refresh first, write after aref_end + one ARBIT cycle
      init_end = 1;
      step();
      aref_req = 1; wr_req = 1; rd_req = 1;
      step();
      chk("aref_first", {aref_en, wr_en, rd_en}, 3'b100);
      aref_req = 0;
      step();
      aref_end = 1;
      step();
      aref_end = 0;
      chk("arbit_gap", {aref_en, wr_en, rd_en}, 3'b000);
      step();
      chk("write_after_aref", {aref_en, wr_en, rd_en}, 3'b010);
      wr_req = 0; rd_req = 0;

      // foreign end pulse ignored, own end returns to ARBIT
      rd_end = 1;
      step();
      rd_end = 0;
      chk("rd_end_ignored", wr_en, 1'b1);
      wr_end = 1;
      step();
      wr_end = 0;
      chk("wr_end_release", {aref_en, wr_en, rd_en}, 3'b000);

      // write/read contention
      pulse_rst();
      init_end = 1; wr_req = 1; rd_req = 1;
      step();
`ifdef SDRAM_ARB_RW_FAIR_EN
      fair_pat = 3'b101;
`else
      fair_pat = 3'b111;
`endif
      for (int i = 0; i < 3; i++) begin
         exp_w = fair_pat[2-i];
         step();
         chk("contend_wr", wr_en, exp_w);
         chk("contend_rd", rd_en, !exp_w);
         wr_end = exp_w; rd_end = !exp_w;
         step();
         wr_end = 0; rd_end = 0;
      end
      wr_req = 0; rd_req = 0;

      // reset during READ aborts at once
      rd_req = 1;
      step();
      rd_req = 0;
      chk("in_read", rd_en, 1'b1);
      step();
      pulse_rst();

      // init_end lost during AREF
      init_end = 1;
      step();
      aref_req = 1;
      step();
      aref_req = 0;
      step();
      chk("in_aref", aref_en, 1'b1);
      init_end = 0; init_cmd = 4'b0011; init_addr = 13'h1f0f;
      step();
      chk("drop_aref_en", aref_en, 1'b0);
      chk("drop_init_pins", pins, {4'b0011, 13'h1f0f, 2'd1});

      // random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 149) == 0) pulse_rst();
         init_end  = ($urandom_range(0, 24) != 0);
         aref_req  = ($urandom_range(0, 5) == 0);
         wr_req    = $urandom_range(0, 1);
         rd_req    = $urandom_range(0, 1);
         aref_end  = ($urandom_range(0, 3) == 0);
         wr_end    = ($urandom_range(0, 3) == 0);
         rd_end    = ($urandom_range(0, 3) == 0);
         init_cmd  = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
         init_addr = AW'($urandom); aref_addr = AW'($urandom); wr_addr = AW'($urandom); rd_addr = AW'($urandom);
         init_ba   = BW'($urandom); aref_ba = BW'($urandom); wr_ba = BW'($urandom); rd_ba = BW'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
